// File: rtl/branch_predictor_if.sv
// Fetch-lookup and resolve-update bundle between the CPU pipeline and branch_predictor.
interface branch_predictor_if #(
  parameter int ADDR_W    = 32,
  parameter int HIST_BITS = 4,
  parameter int STAT_W    = 16
);
  logic [ADDR_W-1:0]    pc_i;
  logic                 pred_taken_o;
  logic                 pred_hit_o;
  logic [ADDR_W-1:0]    pred_target_o;
  logic [HIST_BITS-1:0] pred_ghr_o;
  logic                 upd_valid_i;
  logic [ADDR_W-1:0]    upd_pc_i;
  logic                 upd_taken_i;
  logic [ADDR_W-1:0]    upd_target_i;
  logic                 upd_pred_taken_i;
  logic [ADDR_W-1:0]    upd_pred_target_i;
  logic [HIST_BITS-1:0] upd_ghr_i;
  logic                 mispredict_o;
  logic [ADDR_W-1:0]    redirect_pc_o;
  logic [STAT_W-1:0]    br_cnt_o;
  logic [STAT_W-1:0]    mis_cnt_o;

  modport master (
    output pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_pred_taken_i, upd_pred_target_i, upd_ghr_i,
    input  pred_taken_o, pred_hit_o, pred_target_o, pred_ghr_o,
           mispredict_o, redirect_pc_o, br_cnt_o, mis_cnt_o
  );

  modport slave (
    input  pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_pred_taken_i, upd_pred_target_i, upd_ghr_i,
    output pred_taken_o, pred_hit_o, pred_target_o, pred_ghr_o,
           mispredict_o, redirect_pc_o, br_cnt_o, mis_cnt_o
  );
endinterface

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: 2-bit counter table plus tagged BTB, selectable
// static/bimodal/gshare indexing, with saturating branch and mispredict counters.
module branch_predictor #(
  parameter int ADDR_W    = 32,
  parameter int IDX_BITS  = 6,
  parameter int TAG_BITS  = 8,
  parameter int HIST_BITS = 4,
  parameter int MODE      = 1,
  parameter int STAT_W    = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          ctr     [ENTRIES];
  logic [TAG_BITS-1:0] tag_mem [ENTRIES];
  logic [ADDR_W-1:0]   tgt_mem [ENTRIES];
  logic [ENTRIES-1:0]  valid;
  logic [HIST_BITS-1:0] ghr;
  logic [STAT_W-1:0]   br_cnt;
  logic [STAT_W-1:0]   mis_cnt;

  logic [IDX_BITS-1:0] l_bidx, l_cidx, u_bidx, u_cidx, ghr_ext, upd_ghr_ext;
  logic [TAG_BITS-1:0] l_tag, u_tag;
  logic                hit, taken, mispredict;
  logic [HIST_BITS:0]  ghr_shift;
  logic                unused_bits;

  assign l_bidx      = bp.pc_i[IDX_BITS+1:2];
  assign l_tag       = bp.pc_i[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign u_bidx      = bp.upd_pc_i[IDX_BITS+1:2];
  assign u_tag       = bp.upd_pc_i[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign ghr_ext     = IDX_BITS'(ghr);
  assign upd_ghr_ext = IDX_BITS'(bp.upd_ghr_i);

  // Training uses the history captured at fetch, not the live GHR, so the
  // counter updated is the one that produced the prediction.
  assign l_cidx = (MODE == 2) ? (l_bidx ^ ghr_ext) : l_bidx;
  assign u_cidx = (MODE == 2) ? (u_bidx ^ upd_ghr_ext) : u_bidx;

  assign hit   = valid[l_bidx] && (tag_mem[l_bidx] == l_tag);
  assign taken = (MODE != 0) && hit && ctr[l_cidx][1];

  assign bp.pred_hit_o    = hit;
  assign bp.pred_taken_o  = taken;
  assign bp.pred_target_o = taken ? tgt_mem[l_bidx] : bp.pc_i + ADDR_W'(4);
  assign bp.pred_ghr_o    = ghr;

  assign mispredict = bp.upd_valid_i &&
                      ((bp.upd_taken_i != bp.upd_pred_taken_i) ||
                       (bp.upd_taken_i && (bp.upd_target_i != bp.upd_pred_target_i)));
  assign bp.mispredict_o  = mispredict;
  assign bp.redirect_pc_o = bp.upd_taken_i ? bp.upd_target_i : bp.upd_pc_i + ADDR_W'(4);

  assign bp.br_cnt_o  = br_cnt;
  assign bp.mis_cnt_o = mis_cnt;

  assign ghr_shift   = {ghr, bp.upd_taken_i};
  assign unused_bits = ^{bp.pc_i, bp.upd_pc_i, bp.upd_ghr_i, ghr_shift[HIST_BITS]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctr     <= '{default: 2'b01};
      valid   <= '0;
      ghr     <= '0;
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else if (bp.upd_valid_i) begin
      if (MODE != 0) begin
        if (bp.upd_taken_i) begin
          if (ctr[u_cidx] != 2'b11) ctr[u_cidx] <= ctr[u_cidx] + 2'b01;
        end else begin
          if (ctr[u_cidx] != 2'b00) ctr[u_cidx] <= ctr[u_cidx] - 2'b01;
        end
      end
      if (bp.upd_taken_i) valid[u_bidx] <= 1'b1;
      ghr <= ghr_shift[HIST_BITS-1:0];
      if (br_cnt != '1) br_cnt <= br_cnt + 1'b1;
      if (mispredict && (mis_cnt != '1)) mis_cnt <= mis_cnt + 1'b1;
    end
  end

  // Tag/target payload needs no reset; valid alone gates its use.
  always_ff @(posedge clk_i) begin
    if (!rst_i && bp.upd_valid_i && bp.upd_taken_i) begin
      tag_mem[u_bidx] <= u_tag;
      tgt_mem[u_bidx] <= bp.upd_target_i;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed checks of branch_predictor in static, bimodal, gshare and narrow-stat configurations.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst;
  logic rst_g;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  branch_predictor_if #(.ADDR_W(32), .HIST_BITS(4), .STAT_W(16)) b_if ();
  branch_predictor_if #(.ADDR_W(32), .HIST_BITS(4), .STAT_W(16)) s_if ();
  branch_predictor_if #(.ADDR_W(32), .HIST_BITS(4), .STAT_W(16)) g_if ();
  branch_predictor_if #(.ADDR_W(32), .HIST_BITS(4), .STAT_W(4))  c_if ();

  branch_predictor #(.ADDR_W(32), .IDX_BITS(6), .TAG_BITS(8), .HIST_BITS(4), .MODE(1), .STAT_W(16))
    dut_b (.clk_i(clk), .rst_i(rst), .bp(b_if.slave));
  branch_predictor #(.ADDR_W(32), .IDX_BITS(6), .TAG_BITS(8), .HIST_BITS(4), .MODE(0), .STAT_W(16))
    dut_s (.clk_i(clk), .rst_i(rst), .bp(s_if.slave));
  branch_predictor #(.ADDR_W(32), .IDX_BITS(6), .TAG_BITS(8), .HIST_BITS(4), .MODE(2), .STAT_W(16))
    dut_g (.clk_i(clk), .rst_i(rst_g), .bp(g_if.slave));
  branch_predictor #(.ADDR_W(32), .IDX_BITS(6), .TAG_BITS(8), .HIST_BITS(4), .MODE(1), .STAT_W(4))
    dut_c (.clk_i(clk), .rst_i(rst), .bp(c_if.slave));

  // The static instance sees exactly the bimodal stimulus.
  assign s_if.pc_i              = b_if.pc_i;
  assign s_if.upd_valid_i       = b_if.upd_valid_i;
  assign s_if.upd_pc_i          = b_if.upd_pc_i;
  assign s_if.upd_taken_i       = b_if.upd_taken_i;
  assign s_if.upd_target_i      = b_if.upd_target_i;
  assign s_if.upd_pred_taken_i  = b_if.upd_pred_taken_i;
  assign s_if.upd_pred_target_i = b_if.upd_pred_target_i;
  assign s_if.upd_ghr_i         = b_if.upd_ghr_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic b_upd(input logic v, input logic [31:0] pc, input logic t,
                       input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    b_if.upd_valid_i = v; b_if.upd_pc_i = pc; b_if.upd_taken_i = t;
    b_if.upd_target_i = tgt; b_if.upd_pred_taken_i = pt; b_if.upd_pred_target_i = ptgt;
    b_if.upd_ghr_i = 4'h0;
  endtask

  task automatic g_upd(input logic v, input logic [31:0] pc, input logic t,
                       input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                       input logic [3:0] h);
    g_if.upd_valid_i = v; g_if.upd_pc_i = pc; g_if.upd_taken_i = t;
    g_if.upd_target_i = tgt; g_if.upd_pred_taken_i = pt; g_if.upd_pred_target_i = ptgt;
    g_if.upd_ghr_i = h;
  endtask

  task automatic c_upd(input logic v, input logic t, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt);
    c_if.upd_valid_i = v; c_if.upd_pc_i = 32'h100; c_if.upd_taken_i = t;
    c_if.upd_target_i = tgt; c_if.upd_pred_taken_i = pt; c_if.upd_pred_target_i = ptgt;
    c_if.upd_ghr_i = 4'h0;
  endtask

  initial begin
    rst = 1'b1; rst_g = 1'b1;
    b_if.pc_i = 32'h100; g_if.pc_i = 32'h40; c_if.pc_i = 32'h100;
    b_upd(0, 0, 0, 0, 0, 0);
    g_upd(0, 0, 0, 0, 0, 0, 4'h0);
    c_upd(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; rst_g = 1'b0;
    #4;
    chk("rst_hit", b_if.pred_hit_o, 0);
    chk("rst_taken", b_if.pred_taken_o, 0);
    chk("rst_target", b_if.pred_target_o, 32'h104);
    chk("rst_br_cnt", b_if.br_cnt_o, 0);
    chk("rst_mis_cnt", b_if.mis_cnt_o, 0);

    // First taken resolve of 0x100: mispredict, lookup still sees old state
    tick(); b_upd(1, 32'h100, 1, 32'h200, 0, 32'h104); #4;
    chk("s2_mispredict", b_if.mispredict_o, 1);
    chk("s2_redirect", b_if.redirect_pc_o, 32'h200);
    chk("s2_rbw_hit", b_if.pred_hit_o, 0);
    tick(); b_upd(0, 0, 0, 0, 0, 0); #4;
    chk("s3_hit", b_if.pred_hit_o, 1);
    chk("s3_taken", b_if.pred_taken_o, 1);
    chk("s3_target", b_if.pred_target_o, 32'h200);
    chk("s3_br_cnt", b_if.br_cnt_o, 1);
    chk("s3_mis_cnt", b_if.mis_cnt_o, 1);
    chk("static_hit", s_if.pred_hit_o, 1);
    chk("static_taken", s_if.pred_taken_o, 0);
    chk("static_target", s_if.pred_target_o, 32'h104);

    // Two correct taken resolves saturate the counter at 11
    tick(); b_upd(1, 32'h100, 1, 32'h200, 1, 32'h200); #4;
    chk("s4_no_mispredict", b_if.mispredict_o, 0);
    tick(); b_upd(1, 32'h100, 1, 32'h200, 1, 32'h200);
    tick(); b_upd(1, 32'h100, 0, 32'h200, 1, 32'h200); #4;
    chk("s5_nt_mispredict", b_if.mispredict_o, 1);
    chk("s5_nt_redirect", b_if.redirect_pc_o, 32'h104);
    tick(); b_upd(0, 0, 0, 0, 0, 0); #4;
    chk("s6_hyst_taken", b_if.pred_taken_o, 1);
    chk("s6_hyst_target", b_if.pred_target_o, 32'h200);
    chk("s6_br_cnt", b_if.br_cnt_o, 4);
    chk("s6_mis_cnt", b_if.mis_cnt_o, 2);
    tick(); b_upd(1, 32'h100, 0, 32'h200, 1, 32'h200);
    tick(); b_upd(0, 0, 0, 0, 0, 0); #4;
    chk("s8_weak_nt_taken", b_if.pred_taken_o, 0);
    chk("s8_weak_nt_hit", b_if.pred_hit_o, 1);
    chk("s8_weak_nt_target", b_if.pred_target_o, 32'h104);

    // Retrain taken, then probe the aliasing PC 0x200 (same index, other tag)
    tick(); b_upd(1, 32'h100, 1, 32'h200, 0, 32'h104);
    tick(); b_upd(0, 0, 0, 0, 0, 0); b_if.pc_i = 32'h200; #4;
    chk("alias_hit", b_if.pred_hit_o, 0);
    chk("alias_taken", b_if.pred_taken_o, 0);
    chk("alias_target", b_if.pred_target_o, 32'h204);
    b_if.pc_i = 32'h100; #1;
    chk("retrain_target", b_if.pred_target_o, 32'h200);
    chk("s10_br_cnt", b_if.br_cnt_o, 6);
    chk("s10_mis_cnt", b_if.mis_cnt_o, 4);

    // PC wraparound on both fall-through paths
    tick(); b_if.pc_i = 32'hFFFF_FFFC;
    b_upd(1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0); #4;
    chk("wrap_target", b_if.pred_target_o, 32'h0);
    chk("wrap_redirect", b_if.redirect_pc_o, 32'h0);
    chk("wrap_no_mispredict", b_if.mispredict_o, 0);
    tick(); b_upd(0, 0, 0, 0, 0, 0);

    // Gshare: history shifts and indexes the counter table
    #4;
    chk("g_ghr0", g_if.pred_ghr_o, 4'h0);
    tick(); g_upd(1, 32'h40, 1, 32'h80, 1, 32'h80, 4'h0); #4;
    chk("g_correct_pred", g_if.mispredict_o, 0);
    tick(); g_upd(0, 0, 0, 0, 0, 0, 4'h0); #4;
    chk("g_ghr1", g_if.pred_ghr_o, 4'h1);
    chk("g_hit", g_if.pred_hit_o, 1);
    chk("g_idx_taken", g_if.pred_taken_o, 0);
    chk("g_idx_target", g_if.pred_target_o, 32'h44);
    tick(); g_upd(1, 32'h40, 1, 32'h80, 1, 32'h80, 4'h1);
    tick(); g_upd(1, 32'h80, 0, 32'h0, 0, 32'h84, 4'h3);
    tick(); g_upd(1, 32'h40, 1, 32'h80, 1, 32'h80, 4'h6);
    tick(); g_upd(0, 0, 0, 0, 0, 0, 4'h0); #4;
    chk("g_ghr_1101", g_if.pred_ghr_o, 4'b1101);
    chk("g_br_cnt", g_if.br_cnt_o, 4);
    chk("g_mis_cnt", g_if.mis_cnt_o, 0);
    tick(); rst_g = 1'b1; g_upd(1, 32'h40, 1, 32'h80, 0, 32'h44, 4'hD);
    tick(); rst_g = 1'b0; g_upd(0, 0, 0, 0, 0, 0, 4'h0); #4;
    chk("g_rst_ghr", g_if.pred_ghr_o, 4'h0);
    chk("g_rst_br_cnt", g_if.br_cnt_o, 0);
    chk("g_rst_mis_cnt", g_if.mis_cnt_o, 0);
    chk("g_rst_hit", g_if.pred_hit_o, 0);
    chk("g_rst_target", g_if.pred_target_o, 32'h44);

    // 4-bit stats: 17 target mispredicts saturate both counters
    for (int i = 0; i < 17; i++) begin
      tick(); c_upd(1, 1, 32'h200, 1, 32'h300);
      if (i == 0) begin
        #4;
        chk("c_target_mispredict", c_if.mispredict_o, 1);
      end
    end
    tick(); c_upd(0, 0, 0, 0, 0); #4;
    chk("c_br_sat", c_if.br_cnt_o, 4'hF);
    chk("c_mis_sat", c_if.mis_cnt_o, 4'hF);
    tick(); c_upd(1, 1, 32'h200, 1, 32'h200);
    tick(); c_upd(0, 0, 0, 0, 0); #4;
    chk("c_br_held", c_if.br_cnt_o, 4'hF);
    chk("c_mis_held", c_if.mis_cnt_o, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
